// File: rtl/key_conditioner.sv
// key_conditioner: synchronize, debounce and pulse three active-low pushbuttons.
// Define KEY_AUTOREPEAT_EN to build the key-0 hold/auto-repeat logic.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 30000,
  parameter int HOLD_CYCLES = 1536000,
  parameter int REPEAT_CYCLES = 614400
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_key_n,
  output logic [2:0] o_key_pulse,
  output logic [2:0] o_key_level,
  output logic       o_repeat_active
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {S_IDLE, S_PRESS_CHK, S_HELD, S_REL_CHK} state_t;
  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cfg
    $error("key_conditioner: cycle parameters must be at least 2");
  end
  logic [2:0] sync1, sync2, pressed, press_pulse;
  always_ff @(posedge i_clk)
    if (!i_rst_n) {sync2, sync1} <= '1;
    else {sync2, sync1} <= {sync1, i_key_n};
  assign pressed = ~sync2;
  for (genvar g = 0; g < 3; g++) begin : g_key
    state_t state;
    logic [DW-1:0] cnt;
    logic lvl, pls, rel_done;
    assign rel_done = state == S_REL_CHK && !pressed[g] && cnt == D_LAST;
    always_ff @(posedge i_clk)
      if (!i_rst_n) begin
        state <= S_IDLE;
        cnt <= '0;
        lvl <= 1'b0;
        pls <= 1'b0;
      end else begin
        pls <= 1'b0;
        case (state)
          S_IDLE: if (pressed[g]) begin
            state <= S_PRESS_CHK;
            cnt <= '0;
          end
          S_PRESS_CHK: if (!pressed[g]) begin
            state <= S_IDLE;
            cnt <= '0;
          end else if (cnt == D_LAST) begin
            state <= S_HELD;
            lvl <= 1'b1;
            pls <= 1'b1;
          end else cnt <= cnt + 1'b1;
          S_HELD: if (!pressed[g]) begin
            state <= S_REL_CHK;
            cnt <= '0;
          end
          S_REL_CHK: if (pressed[g]) state <= S_HELD;
          else if (rel_done) begin
            state <= S_IDLE;
            lvl <= 1'b0;
            cnt <= '0;
          end else cnt <= cnt + 1'b1;
        endcase
      end
    assign press_pulse[g] = pls;
    assign o_key_level[g] = lvl;
  end
`ifdef KEY_AUTOREPEAT_EN
  localparam int HW = $clog2(HOLD_CYCLES + REPEAT_CYCLES);
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  logic rep_pulse, held0;
  assign held0 = g_key[0].state == S_HELD;
  // hold count saturates at HOLD_CYCLES so the first repeat fires only once per press
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      hold_cnt <= '0;
      rep_cnt <= '0;
      rep_pulse <= 1'b0;
      o_repeat_active <= 1'b0;
    end else begin
      rep_pulse <= 1'b0;
      if (g_key[0].rel_done) begin
        hold_cnt <= '0;
        rep_cnt <= '0;
        o_repeat_active <= 1'b0;
      end else if (held0) begin
        if (hold_cnt != HW'(HOLD_CYCLES)) hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          o_repeat_active <= 1'b1;
          rep_pulse <= 1'b1;
          rep_cnt <= '0;
        end else if (o_repeat_active) begin
          rep_pulse <= rep_cnt == R_LAST;
          rep_cnt <= rep_cnt == R_LAST ? '0 : rep_cnt + 1'b1;
        end
      end
    end
  assign o_key_pulse = {press_pulse[2:1], press_pulse[0] | rep_pulse};
`else
  assign o_repeat_active = 1'b0;
  assign o_key_pulse = press_pulse;
`endif
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed bench with a pulse scoreboard for key_conditioner.
module tb_key_conditioner;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  typedef struct {
    int cyc;
    logic [2:0] val;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] key_n;
  logic [2:0] key_pulse, key_level;
  logic repeat_active;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  exp_t q[$];
  key_conditioner #(.DEBOUNCE_CYCLES(8), .HOLD_CYCLES(40), .REPEAT_CYCLES(16)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_key_n(key_n),
    .o_key_pulse(key_pulse),
    .o_key_level(key_level),
    .o_repeat_active(repeat_active)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input int c, input logic [2:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    q.push_back(e);
  endtask
  // every nonzero pulse vector must match the oldest expected pulse in cycle and value
  always @(negedge clk)
    if (mon_en && key_pulse !== 3'b000) begin
      if (q.size() == 0) check("spurious_pulse", 32'(key_pulse), 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("pulse_value", 32'(key_pulse), 32'(e.val));
      end
    end
  initial begin
    int t0;
    rst_n = 1'b0;
    key_n = 3'b111;
    step(3);
    check("reset_outputs", 32'({key_pulse, key_level, repeat_active}), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    step(5);
    // clean press on key 1
    t0 = cyc;
    key_n[1] = 1'b0;
    push(t0 + 11, 3'b010);
    step(10);
    check("clean_level_before", 32'(key_level), 32'd0);
    step(1);
    check("clean_level_rise", 32'(key_level), 32'b010);
    step(19);
    key_n[1] = 1'b1;
    step(10);
    check("clean_level_hold", 32'(key_level), 32'b010);
    step(1);
    check("clean_level_fall", 32'(key_level), 32'd0);
    step(5);
    // bouncing key 2 never reaches the debounce threshold
    for (int i = 0; i < 10; i++) begin
      key_n[2] = i[0];
      step(3);
      check("bounce_level", 32'(key_level[2]), 32'd0);
    end
    key_n[2] = 1'b1;
    step(15);
    check("bounce_after", 32'(key_level), 32'd0);
    // release glitch on a held key 1
    t0 = cyc;
    key_n[1] = 1'b0;
    push(t0 + 11, 3'b010);
    step(20);
    key_n[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("glitch_level_high", 32'(key_level[1]), 32'd1);
    end
    key_n[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("glitch_level_recover", 32'(key_level[1]), 32'd1);
    end
    key_n[1] = 1'b1;
    step(12);
    check("glitch_level_fall", 32'(key_level), 32'd0);
    // key 0 held long enough to auto-repeat
    t0 = cyc;
    key_n[0] = 1'b0;
    push(t0 + 11, 3'b001);
    if (AR) begin
      push(t0 + 51, 3'b001);
      push(t0 + 67, 3'b001);
      push(t0 + 83, 3'b001);
      push(t0 + 99, 3'b001);
    end
    step(50);
    check("repeat_before", 32'(repeat_active), 32'd0);
    step(1);
    check("repeat_start", 32'(repeat_active), 32'(AR));
    step(49);
    key_n[0] = 1'b1;
    step(10);
    check("repeat_hold", 32'(repeat_active), 32'(AR));
    check("repeat_level_hold", 32'(key_level), 32'b001);
    step(1);
    check("repeat_end", 32'(repeat_active), 32'd0);
    check("repeat_level_fall", 32'(key_level), 32'd0);
    step(5);
    // keys 0 and 2 together
    t0 = cyc;
    key_n = 3'b010;
    push(t0 + 11, 3'b101);
    step(11);
    check("simul_level", 32'(key_level), 32'b101);
    step(9);
    key_n = 3'b111;
    step(15);
    check("simul_released", 32'(key_level), 32'd0);
    // reset in the middle of a key 1 debounce
    t0 = cyc;
    key_n[1] = 1'b0;
    step(5);
    rst_n = 1'b0;
    step(1);
    check("midreset_out1", 32'({key_pulse, key_level, repeat_active}), 32'd0);
    step(1);
    check("midreset_out2", 32'({key_pulse, key_level, repeat_active}), 32'd0);
    rst_n = 1'b1;
    push(t0 + 18, 3'b010);
    step(10);
    check("midreset_level_before", 32'(key_level), 32'd0);
    step(1);
    check("midreset_level_rise", 32'(key_level), 32'b010);
    step(12);
    key_n[1] = 1'b1;
    step(15);
    check("midreset_released", 32'(key_level), 32'd0);
    check("pending_pulses", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
